// File: rtl/mod_mult_interleaved.sv
// Sequential MSB-first interleaved modular multiplier: result = (a*b) mod n.
// One multiplier bit per clock; operands latched on an accepted start.
module mod_mult_interleaved #(
  parameter int unsigned WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH:0]   r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_err;

  logic             w_bad;
  logic             w_bit;
  logic             w_last;
  logic [WIDTH:0]   w_n_ext;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH:0]   w_r1;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_r2;

  assign w_bad   = (n == '0) || (a >= n) || (b >= n);
  assign w_bit   = r_b[r_cnt];
  assign w_last  = (r_cnt == '0);
  assign w_n_ext = {1'b0, r_n};

  // acc < n always holds between iterations, so both stages fit in WIDTH+1 bits.
  assign w_dbl = r_acc << 1;
  assign w_r1  = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
  assign w_sum = w_r1 + {1'b0, r_a};
  assign w_r2  = w_bit ? ((w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum) : w_r1;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = w_bad ? StDone : StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_n      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == StIdle && start) begin
        r_a   <= a;
        r_b   <= b;
        r_n   <= n;
        r_acc <= '0;
        r_cnt <= CW'(WIDTH - 1);
        r_err <= w_bad;
        if (w_bad) r_result <= '0;
      end else if (r_state == StRun) begin
        r_acc <= w_r2;
        r_cnt <= r_cnt - CW'(1);
        if (w_last) r_result <= w_r2[WIDTH-1:0];
      end
    end
  end

  assign result = r_result;
  assign err    = r_err;
  assign busy   = (r_state != StIdle);
  assign done   = (r_state == StDone);

endmodule

// File: tb/tb_mod_mult_interleaved.sv
// Directed bench for mod_mult_interleaved at WIDTH=8 and WIDTH=256.
module tb_mod_mult_interleaved;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start8;
  logic [7:0] a8, b8, n8, res8;
  logic       busy8, done8, err8;

  logic         start256;
  logic [255:0] a256, b256, n256, res256;
  logic         busy256, done256, err256;

  int n_cmp  = 0;
  int n_fail = 0;

  mod_mult_interleaved #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .reset  (reset),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .n      (n8),
    .result (res8),
    .busy   (busy8),
    .done   (done8),
    .err    (err8)
  );

  mod_mult_interleaved #(.WIDTH(256)) u_dut256 (
    .clk    (clk),
    .reset  (reset),
    .start  (start256),
    .a      (a256),
    .b      (b256),
    .n      (n256),
    .result (res256),
    .busy   (busy256),
    .done   (done256),
    .err    (err256)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait8(output int cyc);
    cyc = 0;
    while (!done8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait256(output int cyc);
    cyc = 0;
    while (!done256 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic [7:0] tn, input logic [7:0] er, input logic ee,
                      input int el);
    int c;
    @(negedge clk);
    a8 = ta; b8 = tb_; n8 = tn; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait8(c);
    chk({tag, "_lat"}, 256'(c), 256'(el));
    chk({tag, "_res"}, 256'(res8), 256'(er));
    chk({tag, "_err"}, 256'(err8), 256'(ee));
    chk({tag, "_busy"}, 256'(busy8), 256'(1));
    @(negedge clk);
    chk({tag, "_done_off"}, 256'(done8), 256'(0));
    chk({tag, "_busy_off"}, 256'(busy8), 256'(0));
    repeat (2) @(negedge clk);
    chk({tag, "_hold"}, 256'(res8), 256'(er));
  endtask

  task automatic run256(input string tag, input logic [255:0] ta, input logic [255:0] tb_,
                        input logic [255:0] tn, input logic [255:0] er);
    int c;
    @(negedge clk);
    a256 = ta; b256 = tb_; n256 = tn; start256 = 1'b1;
    @(negedge clk);
    start256 = 1'b0;
    wait256(c);
    chk({tag, "_lat"}, 256'(c), 256'(256));
    chk({tag, "_res"}, res256, er);
    chk({tag, "_err"}, 256'(err256), 256'(0));
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    int c;
    logic [255:0] all1, rn, ra, rb, rexp;
    logic [511:0] prod;

    reset = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; n8 = '0;
    start256 = 1'b0; a256 = '0; b256 = '0; n256 = '0;
    repeat (2) @(negedge clk);
    chk("rst_res8", 256'(res8), 256'(0));
    chk("rst_busy8", 256'(busy8), 256'(0));
    chk("rst_done8", 256'(done8), 256'(0));
    chk("rst_err8", 256'(err8), 256'(0));
    chk("rst_res256", res256, 256'(0));
    reset = 1'b0;

    // Basic products, zero operands still take all 8 iterations.
    run8("t1", 8'd200, 8'd100, 8'd251, 8'd171, 1'b0, 8);
    run8("t2a", 8'd250, 8'd250, 8'd251, 8'd1, 1'b0, 8);
    run8("t2b", 8'd0, 8'd77, 8'd251, 8'd0, 1'b0, 8);
    run8("b0", 8'd77, 8'd0, 8'd251, 8'd0, 1'b0, 8);
    run8("n1", 8'd0, 8'd0, 8'd1, 8'd0, 1'b0, 8);
    run8("full", 8'd254, 8'd253, 8'd255, 8'd2, 1'b0, 8);
    run8("t1r", 8'd200, 8'd100, 8'd251, 8'd171, 1'b0, 8);

    // Invalid operands complete on the next cycle and clear result.
    run8("n0", 8'd5, 8'd5, 8'd0, 8'd0, 1'b1, 0);
    run8("a_ge_n", 8'd251, 8'd3, 8'd251, 8'd0, 1'b1, 0);
    run8("b_ge_n", 8'd3, 8'd252, 8'd251, 8'd0, 1'b1, 0);

    // start during RUN and during DONE is ignored.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; n8 = 8'd251; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait8(c);
    chk("t4_lat", 256'(c + 4), 256'(8));
    chk("t4_res", 256'(res8), 256'(171));
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("t4_done_start_busy", 256'(busy8), 256'(0));
    @(negedge clk);
    chk("t4_done_start_idle", 256'(busy8), 256'(0));
    chk("t4_done_start_res", 256'(res8), 256'(171));

    // Reset mid-RUN aborts immediately.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; n8 = 8'd251; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_busy", 256'(busy8), 256'(0));
    chk("t5_done", 256'(done8), 256'(0));
    chk("t5_res", 256'(res8), 256'(0));
    chk("t5_err", 256'(err8), 256'(0));
    @(negedge clk);
    reset = 1'b0;
    run8("t5b", 8'd13, 8'd17, 8'd23, 8'd14, 1'b0, 8);

    // WIDTH=256: hand-checked corners around n = 2^256-1.
    all1 = '1;
    run256("w_m1sq", all1 - 256'd1, all1 - 256'd1, all1, 256'd1);
    run256("w_2pow", 256'd1 << 255, 256'd2, all1, 256'd1);
    run256("w_small", 256'd13, 256'd17, 256'd23, 256'd14);

    // WIDTH=256: random triples against a wide behavioural product.
    for (int i = 0; i < 40; i++) begin
      rn = (i % 10 == 0) ? all1 : rnd256();
      rn[0] = i[0];
      if (rn == '0) rn = 256'd2;
      ra = rnd256() % rn;
      rb = rnd256() % rn;
      prod = {256'd0, ra} * {256'd0, rb};
      rexp = 256'(prod % {256'd0, rn});
      run256($sformatf("w_rnd%0d", i), ra, rb, rn, rexp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
